// File: rtl/ctl_round.sv
// ctl_round: game-flow sequencer feeding ctl_duck -- duck launches, ammo,
// escape timing, hit counting, round progression and game over.
//
// state     | meaning
// IDLE      | power-up, waiting for a start_btn rise
// NEW_GAME  | one cycle, clears round/score and launches duck 1
// LAUNCH    | one cycle, game_start high, launch parameters valid
// FLYING    | duck in the air: shots, hit detection, fly timeout
// GRACE     | two cycles after the last shot so a late hit still counts
// FALLING   | hit duck falling, wait for duck_hit to drop
// ESCAPE    | missed duck leaves the screen, ammo forced empty
// NEXT      | one cycle, decide next launch, round advance or game over
// GAME_OVER | round failed, waiting for a start_btn rise
module ctl_round #(
  parameter int          DUCKS_PER_ROUND = 10,
  parameter int          PASS_HITS       = 6,
  parameter int          SHOTS_PER_DUCK  = 3,
  parameter int          FLY_TIMEOUT     = 300,
  parameter int          ESCAPE_FRAMES   = 60,
  parameter int          BASE_H_SPD      = 2,
  parameter int          BASE_V_SPD      = 4,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_frame,
  input  logic       start_btn,
  input  logic       shot,
  input  logic       duck_hit,
  output logic       game_start,
  output logic       no_ammo,
  output logic [1:0] ammo,
  output logic       duck_direction,
  output logic [4:0] duck_h_spd,
  output logic [4:0] duck_v_spd,
  output logic [9:0] duck_start_x,
  output logic [3:0] duck_index,
  output logic [3:0] hit_count,
  output logic [3:0] round_num,
  output logic       game_over
);

  localparam int TMR_MAX = (FLY_TIMEOUT > ESCAPE_FRAMES) ? FLY_TIMEOUT : ESCAPE_FRAMES;
  localparam int TW      = $clog2(TMR_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_NEW_GAME, S_LAUNCH, S_FLYING, S_GRACE,
    S_FALLING, S_ESCAPE, S_NEXT, S_GAME_OVER
  } state_t;

  state_t        state;
  logic [15:0]   lfsr;
  logic          lfsr_fb;
  logic          start_q, hit_q;
  logic          start_rise, hit_rise, hit_fall;
  logic [TW-1:0] tmr;
  logic          grace_cnt;

  logic          load_launch, round_adv;
  logic [3:0]    launch_rnd, launch_idx, round_inc;

  function automatic logic [4:0] sat5(input logic [5:0] v);
    sat5 = v[5] ? 5'd31 : v[4:0];
  endfunction

  assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign start_rise = start_btn & ~start_q;
  assign hit_rise   = duck_hit & ~hit_q;
  assign hit_fall   = ~duck_hit & hit_q;
  assign no_ammo    = (ammo == 2'd0);
  assign round_inc  = (round_num == 4'd15) ? 4'd15 : round_num + 4'd1;

  // Launch decision shared by NEW_GAME and NEXT so both load identical parameters.
  always_comb begin
    load_launch = 1'b0;
    round_adv   = 1'b0;
    launch_rnd  = round_num;
    launch_idx  = duck_index + 4'd1;
    if (state == S_NEW_GAME) begin
      load_launch = 1'b1;
    end else if (state == S_NEXT) begin
      if (duck_index < 4'(DUCKS_PER_ROUND)) begin
        load_launch = 1'b1;
      end else if (hit_count >= 4'(PASS_HITS)) begin
        load_launch = 1'b1;
        round_adv   = 1'b1;
        launch_rnd  = round_inc;
        launch_idx  = 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      lfsr           <= LFSR_SEED;
      start_q        <= 1'b0;
      hit_q          <= 1'b0;
      tmr            <= '0;
      grace_cnt      <= 1'b0;
      game_start     <= 1'b0;
      ammo           <= 2'd0;
      duck_direction <= 1'b0;
      duck_h_spd     <= 5'd0;
      duck_v_spd     <= 5'd0;
      duck_start_x   <= 10'd0;
      duck_index     <= 4'd0;
      hit_count      <= 4'd0;
      round_num      <= 4'd0;
      game_over      <= 1'b0;
    end else begin
      lfsr       <= {lfsr[14:0], lfsr_fb};
      start_q    <= start_btn;
      hit_q      <= duck_hit;
      game_start <= 1'b0;

      case (state)
        S_IDLE, S_GAME_OVER: begin
          if (start_rise) begin
            state      <= S_NEW_GAME;
            round_num  <= 4'd0;
            hit_count  <= 4'd0;
            duck_index <= 4'd0;
            game_over  <= 1'b0;
          end
        end
        S_NEW_GAME: state <= S_LAUNCH;
        S_LAUNCH:   state <= S_FLYING;
        S_FLYING: begin
          if (hit_rise) begin
            hit_count <= hit_count + 4'd1;
            state     <= S_FALLING;
          end else if (shot && ammo == 2'd1) begin
            ammo      <= 2'd0;
            grace_cnt <= 1'b1;
            state     <= S_GRACE;
          end else begin
            if (shot && ammo != 2'd0)
              ammo <= ammo - 2'd1;
            if (new_frame) begin
              if (tmr == TW'(1)) begin
                ammo  <= 2'd0;
                tmr   <= TW'(ESCAPE_FRAMES);
                state <= S_ESCAPE;
              end else begin
                tmr <= tmr - TW'(1);
              end
            end
          end
        end
        S_GRACE: begin
          if (hit_rise) begin
            hit_count <= hit_count + 4'd1;
            state     <= S_FALLING;
          end else if (grace_cnt) begin
            grace_cnt <= 1'b0;
          end else begin
            tmr   <= TW'(ESCAPE_FRAMES);
            state <= S_ESCAPE;
          end
        end
        S_FALLING: if (hit_fall) state <= S_NEXT;
        S_ESCAPE: begin
          ammo <= 2'd0;
          if (new_frame) begin
            if (tmr == TW'(1)) state <= S_NEXT;
            else               tmr   <= tmr - TW'(1);
          end
        end
        S_NEXT: begin
          if (round_adv) hit_count <= 4'd0;
          if (load_launch) begin
            state <= S_LAUNCH;
          end else begin
            state     <= S_GAME_OVER;
            game_over <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Parameters are sampled from the LFSR on the edge entering LAUNCH and
      // then held until the next launch.
      if (load_launch) begin
        game_start     <= 1'b1;
        ammo           <= 2'(SHOTS_PER_DUCK);
        duck_index     <= launch_idx;
        round_num      <= launch_rnd;
        tmr            <= TW'(FLY_TIMEOUT);
        duck_direction <= lfsr[9];
        duck_start_x   <= 10'd64 + {1'b0, lfsr[8:0]};
        duck_h_spd     <= sat5(6'(BASE_H_SPD) + {2'b00, launch_rnd});
        duck_v_spd     <= sat5(6'(BASE_V_SPD) + {4'b0000, lfsr[11:10]} + {2'b00, launch_rnd});
      end
    end
  end

endmodule

// File: tb/tb_ctl_round.sv
// Directed bench for ctl_round: launch timing, ammo, escape, hits, timeout,
// round advance, game over, restart and async reset.
module tb_ctl_round;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       new_frame, start_btn, shot, duck_hit;
  logic       game_start, no_ammo, duck_direction, game_over;
  logic [1:0] ammo;
  logic [4:0] duck_h_spd, duck_v_spd;
  logic [9:0] duck_start_x;
  logic [3:0] duck_index, hit_count, round_num;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11; ref_prev holds the
  // value the DUT sampled on the most recent edge.
  logic [15:0] ref_lfsr, ref_prev;

  ctl_round dut (
    .clk(clk), .rst(rst), .new_frame(new_frame), .start_btn(start_btn),
    .shot(shot), .duck_hit(duck_hit), .game_start(game_start), .no_ammo(no_ammo),
    .ammo(ammo), .duck_direction(duck_direction), .duck_h_spd(duck_h_spd),
    .duck_v_spd(duck_v_spd), .duck_start_x(duck_start_x), .duck_index(duck_index),
    .hit_count(hit_count), .round_num(round_num), .game_over(game_over)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_lfsr <= 16'hACE1;
      ref_prev <= 16'hACE1;
    end else begin
      ref_prev <= ref_lfsr;
      ref_lfsr <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Plays one duck from FLYING and returns just after the NEXT decision edge.
  task automatic run_duck(input bit hit);
    if (hit) begin
      duck_hit = 1'b1; tick;
      duck_hit = 1'b0; tick;
      tick;
    end else begin
      shot = 1'b1; repeat (3) tick;
      shot = 1'b0; repeat (2) tick;
      new_frame = 1'b1; repeat (60) tick;
      new_frame = 1'b0; tick;
    end
  endtask

  task automatic test_reset;
    new_frame = 1'b0; start_btn = 1'b0; shot = 1'b0; duck_hit = 1'b0;
    rst = 1'b1;
    repeat (2) tick;
    n_checks++; if (game_start !== 1'b0) begin n_fail++; $display("FAIL reset_game_start: got %b want 0", game_start); end
    n_checks++; if (no_ammo !== 1'b1) begin n_fail++; $display("FAIL reset_no_ammo: got %b want 1", no_ammo); end
    n_checks++; if (ammo !== 2'd0) begin n_fail++; $display("FAIL reset_ammo: got %0d want 0", ammo); end
    n_checks++; if ({duck_index, hit_count, round_num} !== 12'd0) begin n_fail++; $display("FAIL reset_counters: got %h want 000", {duck_index, hit_count, round_num}); end
    n_checks++; if ({duck_direction, duck_h_spd, duck_v_spd, duck_start_x, game_over} !== 22'd0) begin n_fail++; $display("FAIL reset_params: got %h want 0", {duck_direction, duck_h_spd, duck_v_spd, duck_start_x, game_over}); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_start;
    logic [9:0] ex_x, x0;
    int         ev;
    start_btn = 1'b1; tick;
    n_checks++; if (game_start !== 1'b0) begin n_fail++; $display("FAIL start_early_pulse: got %b want 0", game_start); end
    tick;
    ex_x = 10'd64 + {1'b0, ref_prev[8:0]};
    ev   = 4 + int'(ref_prev[11:10]);
    n_checks++; if (game_start !== 1'b1) begin n_fail++; $display("FAIL start_pulse: got %b want 1", game_start); end
    n_checks++; if (ammo !== 2'd3) begin n_fail++; $display("FAIL start_ammo: got %0d want 3", ammo); end
    n_checks++; if (duck_index !== 4'd1) begin n_fail++; $display("FAIL start_index: got %0d want 1", duck_index); end
    n_checks++; if (duck_h_spd !== 5'd2) begin n_fail++; $display("FAIL start_h_spd: got %0d want 2", duck_h_spd); end
    n_checks++; if (duck_start_x !== ex_x) begin n_fail++; $display("FAIL start_x: got %0d want %0d", duck_start_x, ex_x); end
    n_checks++; if (duck_start_x < 10'd64 || duck_start_x > 10'd575) begin n_fail++; $display("FAIL start_x_range: got %0d want 64..575", duck_start_x); end
    n_checks++; if (duck_direction !== ref_prev[9]) begin n_fail++; $display("FAIL start_dir: got %b want %b", duck_direction, ref_prev[9]); end
    n_checks++; if (int'(duck_v_spd) != ev) begin n_fail++; $display("FAIL start_v_spd: got %0d want %0d", duck_v_spd, ev); end
    x0 = duck_start_x;
    tick;
    n_checks++; if (game_start !== 1'b0) begin n_fail++; $display("FAIL start_single_pulse: got %b want 0", game_start); end
    n_checks++; if (duck_start_x !== x0) begin n_fail++; $display("FAIL start_x_stable: got %0d want %0d", duck_start_x, x0); end
    start_btn = 1'b0;
  endtask

  task automatic test_miss;
    shot = 1'b1; tick;
    n_checks++; if (ammo !== 2'd2) begin n_fail++; $display("FAIL miss_ammo2: got %0d want 2", ammo); end
    tick;
    n_checks++; if (ammo !== 2'd1) begin n_fail++; $display("FAIL miss_ammo1: got %0d want 1", ammo); end
    tick;
    n_checks++; if (ammo !== 2'd0 || no_ammo !== 1'b1) begin n_fail++; $display("FAIL miss_ammo0: got ammo %0d no_ammo %b want 0 1", ammo, no_ammo); end
    shot = 1'b1; tick;
    n_checks++; if (ammo !== 2'd0) begin n_fail++; $display("FAIL miss_no_wrap: got %0d want 0", ammo); end
    shot = 1'b0; tick;
    new_frame = 1'b1; repeat (59) tick;
    n_checks++; if (game_start !== 1'b0 || ammo !== 2'd0) begin n_fail++; $display("FAIL miss_escape_early: got start %b ammo %0d want 0 0", game_start, ammo); end
    tick;
    new_frame = 1'b0; tick;
    n_checks++; if (game_start !== 1'b1 || ammo !== 2'd3 || duck_index !== 4'd2) begin n_fail++; $display("FAIL miss_relaunch: got start %b ammo %0d idx %0d want 1 3 2", game_start, ammo, duck_index); end
    tick;
  endtask

  task automatic test_hit;
    shot = 1'b1; tick; shot = 1'b0;
    duck_hit = 1'b1; tick;
    n_checks++; if (hit_count !== 4'd1 || ammo !== 2'd2) begin n_fail++; $display("FAIL hit_count: got hits %0d ammo %0d want 1 2", hit_count, ammo); end
    shot = 1'b1; tick; shot = 1'b0;
    n_checks++; if (ammo !== 2'd2) begin n_fail++; $display("FAIL hit_shot_in_fall: got %0d want 2", ammo); end
    duck_hit = 1'b0; tick; tick;
    n_checks++; if (game_start !== 1'b1 || duck_index !== 4'd3 || hit_count !== 4'd1) begin n_fail++; $display("FAIL hit_relaunch: got start %b idx %0d hits %0d want 1 3 1", game_start, duck_index, hit_count); end
    tick;
  endtask

  task automatic test_timeout;
    new_frame = 1'b1; repeat (299) tick;
    n_checks++; if (ammo !== 2'd3) begin n_fail++; $display("FAIL timeout_early: got ammo %0d want 3", ammo); end
    tick;
    n_checks++; if (ammo !== 2'd0 || no_ammo !== 1'b1 || hit_count !== 4'd1) begin n_fail++; $display("FAIL timeout_escape: got ammo %0d no_ammo %b hits %0d want 0 1 1", ammo, no_ammo, hit_count); end
    repeat (60) tick;
    new_frame = 1'b0; tick;
    n_checks++; if (game_start !== 1'b1 || duck_index !== 4'd4) begin n_fail++; $display("FAIL timeout_relaunch: got start %b idx %0d want 1 4", game_start, duck_index); end
    tick;
  endtask

  task automatic test_round_pass;
    bit [6:0] pat;
    int       ev;
    pat = 7'b1010111;
    for (int i = 0; i < 7; i++) begin
      run_duck(pat[i]);
      if (i == 5) begin
        n_checks++; if (duck_index !== 4'd10 || hit_count !== 4'd5) begin n_fail++; $display("FAIL round_last_duck: got idx %0d hits %0d want 10 5", duck_index, hit_count); end
      end
      if (i < 6) tick;
    end
    ev = 4 + int'(ref_prev[11:10]) + 1;
    n_checks++; if (round_num !== 4'd1 || hit_count !== 4'd0 || duck_index !== 4'd1) begin n_fail++; $display("FAIL round_advance: got round %0d hits %0d idx %0d want 1 0 1", round_num, hit_count, duck_index); end
    n_checks++; if (duck_h_spd !== 5'd3 || game_start !== 1'b1) begin n_fail++; $display("FAIL round_h_spd: got h %0d start %b want 3 1", duck_h_spd, game_start); end
    n_checks++; if (int'(duck_v_spd) != ev) begin n_fail++; $display("FAIL round_v_spd: got %0d want %0d", duck_v_spd, ev); end
    tick;
  endtask

  task automatic test_game_over;
    start_btn = 1'b1; tick;
    n_checks++; if (duck_index !== 4'd1 || round_num !== 4'd1 || game_over !== 1'b0) begin n_fail++; $display("FAIL over_start_ignored: got idx %0d round %0d over %b want 1 1 0", duck_index, round_num, game_over); end
    for (int i = 0; i < 10; i++) begin
      run_duck(i < 5);
      if (i < 9) tick;
    end
    n_checks++; if (game_over !== 1'b1 || hit_count !== 4'd5 || game_start !== 1'b0) begin n_fail++; $display("FAIL over_enter: got over %b hits %0d start %b want 1 5 0", game_over, hit_count, game_start); end
    repeat (3) tick;
    n_checks++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL over_held_start: got %b want 1", game_over); end
    start_btn = 1'b0; tick;
    start_btn = 1'b1; tick;
    n_checks++; if (game_over !== 1'b0 || round_num !== 4'd0) begin n_fail++; $display("FAIL over_restart: got over %b round %0d want 0 0", game_over, round_num); end
    tick;
    n_checks++; if (game_start !== 1'b1 || duck_index !== 4'd1 || hit_count !== 4'd0 || duck_h_spd !== 5'd2) begin n_fail++; $display("FAIL over_relaunch: got start %b idx %0d hits %0d h %0d want 1 1 0 2", game_start, duck_index, hit_count, duck_h_spd); end
    start_btn = 1'b0; tick;
  endtask

  task automatic test_hit_timeout;
    new_frame = 1'b1; repeat (299) tick;
    duck_hit = 1'b1; tick;
    new_frame = 1'b0;
    n_checks++; if (hit_count !== 4'd1 || ammo !== 2'd3 || no_ammo !== 1'b0) begin n_fail++; $display("FAIL hit_vs_timeout: got hits %0d ammo %0d no_ammo %b want 1 3 0", hit_count, ammo, no_ammo); end
    duck_hit = 1'b0; tick; tick;
    n_checks++; if (game_start !== 1'b1 || duck_index !== 4'd2) begin n_fail++; $display("FAIL hit_vs_timeout_next: got start %b idx %0d want 1 2", game_start, duck_index); end
    tick;
  endtask

  task automatic test_async_reset;
    shot = 1'b1; tick; shot = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (ammo !== 2'd0 || no_ammo !== 1'b1 || game_start !== 1'b0) begin n_fail++; $display("FAIL arst_ammo: got ammo %0d no_ammo %b start %b want 0 1 0", ammo, no_ammo, game_start); end
    n_checks++; if ({duck_index, hit_count, round_num} !== 12'd0 || duck_start_x !== 10'd0 || duck_h_spd !== 5'd0 || game_over !== 1'b0) begin n_fail++; $display("FAIL arst_state: got idx %0d hits %0d x %0d h %0d want 0 0 0 0", duck_index, hit_count, duck_start_x, duck_h_spd); end
    rst = 1'b0;
    repeat (3) tick;
    n_checks++; if (game_start !== 1'b0 || duck_index !== 4'd0) begin n_fail++; $display("FAIL arst_no_pending: got start %b idx %0d want 0 0", game_start, duck_index); end
  endtask

  initial begin
    test_reset;
    test_start;
    test_miss;
    test_hit;
    test_timeout;
    test_round_pass;
    test_game_over;
    test_hit_timeout;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
